// File: rtl/util_width_conv_fifo_pkg.sv
// rtl/util_width_conv_fifo_pkg.sv - shared helpers for the packing width-converter FIFO
package util_width_conv_fifo_pkg;

  // Ceiling log2 usable in parameter declarations; clog2(1) == 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/util_sdp_ram.sv
// rtl/util_sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module util_sdp_ram
  import util_width_conv_fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read-first: a same-edge write to raddr returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/util_width_conv_fifo.sv
// rtl/util_width_conv_fifo.sv - packing FIFO DIN_W -> DIN_W*RATIO with flush and sticky overflow
// Define UTIL_WCF_ALMOST_EN to add registered almost_full/almost_empty ports.
module util_width_conv_fifo
  import util_width_conv_fifo_pkg::*;
#(
  parameter int DIN_W = 32,
  parameter int RATIO = 2,
  parameter int DEPTH = 16,
  parameter int CNT_W = clog2(DEPTH * RATIO) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wren,
  input  logic [DIN_W-1:0]       din,
  input  logic                   flush,
  input  logic                   rden,
  output logic [DIN_W*RATIO-1:0] dout,
  output logic                   dout_vld,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       dcnt,
  output logic                   ovf
`ifdef UTIL_WCF_ALMOST_EN
  ,
  output logic                   almost_full,
  output logic                   almost_empty
`endif
);

  localparam int DOUT_W = DIN_W * RATIO;
  localparam int LANE_W = clog2(RATIO);
  localparam int PTR_W  = clog2(DEPTH);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);
  localparam logic [PTR_W:0]    WC_FULL   = (PTR_W + 1)'(DEPTH);

  logic [DOUT_W-1:0] pack_q, pack_d, word;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]    wcount_q, wcount_d;
  logic              dout_vld_q, ovf_q, ovf_d;
  logic              wr_acc, rd_acc, room;
  logic              fill_push, flush_push, push;

  assign full   = (wcount_q == WC_FULL) && (lane_q == LANE_LAST);
  assign empty  = (wcount_q == '0);
  assign wr_acc = wren && !full;
  assign rd_acc = rden && !empty;
  // A same-cycle pop frees the slot a flush needs when storage is full.
  assign room   = (wcount_q != WC_FULL) || rd_acc;

  always_comb begin
    word = pack_q;
    for (int i = 0; i < RATIO; i++) begin
      if (wr_acc && (lane_q == LANE_W'(i))) begin
        word[i*DIN_W +: DIN_W] = din;
      end
    end
    fill_push  = wr_acc && (lane_q == LANE_LAST);
    flush_push = flush && !fill_push && room && ((lane_q != '0) || wr_acc);
    push       = fill_push || flush_push;
    // Packer is cleared on push so unfilled lanes of a flushed word read as zero.
    pack_d     = push ? '0 : word;
    lane_d     = push ? '0 : lane_q + LANE_W'(wr_acc);
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = rd_acc ? rptr_q + 1'b1 : rptr_q;
    wcount_d   = wcount_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(rd_acc);
    ovf_d      = ovf_q || (wren && full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q     <= '0;
      lane_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      wcount_q   <= '0;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      pack_q     <= pack_d;
      lane_q     <= lane_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      wcount_q   <= wcount_d;
      dout_vld_q <= rd_acc;
      ovf_q      <= ovf_d;
    end
  end

  util_sdp_ram #(
    .WIDTH (DOUT_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wptr_q),
    .wdata (word),
    .re    (rd_acc),
    .raddr (rptr_q),
    .rdata (dout)
  );

  // RATIO is a power of two, so stored*RATIO + lane is a plain concatenation.
  assign dcnt     = CNT_W'({wcount_q, lane_q});
  assign dout_vld = dout_vld_q;
  assign ovf      = ovf_q;

`ifdef UTIL_WCF_ALMOST_EN
  logic almost_full_q, almost_empty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (wcount_d >= (PTR_W + 1)'(DEPTH - 2));
      almost_empty_q <= (wcount_d <= (PTR_W + 1)'(1));
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule
